mem_access_arbiter: RTL and testbench

// - Two-port arbiter and access sequencer for the 8x8-bit memory array.
// - Accepts read/write commands from two requesters, picks one, and sequences the array.
// - The array side drives the word-line decoder address/valid and the array read/write enables.
// - Sequence: decode setup, enable pulse, data return. One access in flight at a time.
//

---
 rtl/mem_access_arbiter_if.sv | 32 +++
 rtl/mem_access_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_arbiter_if.sv
// Bus bundle between the two requesters, the access arbiter and the 8x8 array.
// The slave modport is the arbiter's view of it; the master modport is the requester/array side.
interface mem_access_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic [1:0]        i_req;
  logic [1:0]        i_we;
  logic [ADDR_W-1:0] i_addr0;
  logic [ADDR_W-1:0] i_addr1;
  logic [DATA_W-1:0] i_wdata0;
  logic [DATA_W-1:0] i_wdata1;
  logic [1:0]        o_gnt;
  logic [1:0]        o_done;
  logic [DATA_W-1:0] o_rdata;
  logic [ADDR_W-1:0] o_k_address;
  logic              o_valid;
  logic              o_write_en;
  logic              o_read_en;
  logic [DATA_W-1:0] o_wdata;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_req, i_we, i_addr0, i_addr1, i_wdata0, i_wdata1, i_mem_rdata,
    output o_gnt, o_done, o_rdata, o_k_address, o_valid, o_write_en, o_read_en, o_wdata
  );

  modport master (
    output i_req, i_we, i_addr0, i_addr1, i_wdata0, i_wdata1, i_mem_rdata,
    input  o_gnt, o_done, o_rdata, o_k_address, o_valid, o_write_en, o_read_en, o_wdata
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Two-requester arbiter and access sequencer for the 8x8-bit array (setup, enable, done).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed priority to requester 0.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a request; winner command latched on accept edge
// SETUP  | grant pulse, decoder address/valid settle, enables off
// ACCESS | read or write strobe held for ACCESS_CYCLES cycles
// DONE   | completion pulse, read data presented, decoder invalid
module mem_access_arbiter #(
  parameter int ADDR_W        = 3,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 1
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  mem_access_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] ACC_LOAD = 2'(ACCESS_CYCLES - 1);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              win_q, win_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              valid_q, valid_d;
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;
  logic              pick;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // ptr_q holds the index of the requester granted last
  logic              ptr_q, ptr_d;

  always_comb begin
    pick = 1'b0;
    if (bus.i_req[0] && bus.i_req[1]) begin
      pick = ~ptr_q;
    end else if (bus.i_req[1]) begin
      pick = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && (|bus.i_req)) begin
      ptr_d = pick;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    pick = ~bus.i_req[0];
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    win_d   = win_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = 1'b0;
    wen_d   = 1'b0;
    ren_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|bus.i_req) begin
          win_d   = pick;
          we_d    = bus.i_we[pick];
          addr_d  = pick ? bus.i_addr1  : bus.i_addr0;
          wdata_d = pick ? bus.i_wdata1 : bus.i_wdata0;
          gnt_d   = pick ? 2'b10 : 2'b01;
          valid_d = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = ACC_LOAD;
        valid_d = 1'b1;
        wen_d   = we_q;
        ren_d   = ~we_q;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == 2'd0) begin
          done_d  = win_q ? 2'b10 : 2'b01;
          state_d = ST_DONE;
          // array read data is only guaranteed while the read strobe is up
          if (!we_q) begin
            rdata_d = bus.i_mem_rdata;
          end
        end else begin
          cnt_d   = cnt_q - 2'd1;
          valid_d = 1'b1;
          wen_d   = we_q;
          ren_d   = ~we_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      we_q    <= 1'b0;
      win_q   <= 1'b0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
    end
  end

  assign bus.o_gnt       = gnt_q;
  assign bus.o_done      = done_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_k_address = addr_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_write_en  = wen_q;
  assign bus.o_read_en   = ren_q;
  assign bus.o_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: one DUT with a single-cycle access, one with three.
// Outputs are sampled 1 ns after the rising edge; ctl packs {gnt, done, valid, write_en, read_en}.
module tb_mem_access_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_arbiter_if #(.ADDR_W(3), .DATA_W(8)) bus ();
  mem_access_arbiter_if #(.ADDR_W(3), .DATA_W(8)) bus3 ();

  mem_access_arbiter #(.ADDR_W(3), .DATA_W(8), .ACCESS_CYCLES(1)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  mem_access_arbiter #(.ADDR_W(3), .DATA_W(8), .ACCESS_CYCLES(3)) u_dut3 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus3.slave)
  );

  logic [7:0] mem [8];
  always @(posedge clk) begin
    if (bus.o_write_en) mem[bus.o_k_address] <= bus.o_wdata;
  end
  assign bus.i_mem_rdata  = bus.o_read_en  ? mem[bus.o_k_address] : 8'h00;
  assign bus3.i_mem_rdata = bus3.o_read_en ? 8'h3C : 8'h00;

  logic [6:0] ctl, ctl3;
  assign ctl  = {bus.o_gnt,  bus.o_done,  bus.o_valid,  bus.o_write_en,  bus.o_read_en};
  assign ctl3 = {bus3.o_gnt, bus3.o_done, bus3.o_valid, bus3.o_write_en, bus3.o_read_en};

  int n_chk = 0;
  int n_fail = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_req = 2'b00;   bus.i_we = 2'b00;
    bus.i_addr0 = 3'd0;  bus.i_addr1 = 3'd0;
    bus.i_wdata0 = 8'h00; bus.i_wdata1 = 8'h00;
    bus3.i_req = 2'b00;  bus3.i_we = 2'b00;
    bus3.i_addr0 = 3'd0; bus3.i_addr1 = 3'd0;
    bus3.i_wdata0 = 8'h00; bus3.i_wdata1 = 8'h00;
  endtask

  task automatic test_reset();
    n_chk++;
    if (ctl !== 7'd0 || bus.o_rdata !== 8'h00 || bus.o_k_address !== 3'd0 || bus.o_wdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_dut1 ctl=%b rdata=%h addr=%0d wdata=%h required all zero",
               ctl, bus.o_rdata, bus.o_k_address, bus.o_wdata);
    end
    n_chk++;
    if (ctl3 !== 7'd0 || bus3.o_rdata !== 8'h00 || bus3.o_k_address !== 3'd0 || bus3.o_wdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_dut3 ctl=%b rdata=%h addr=%0d wdata=%h required all zero",
               ctl3, bus3.o_rdata, bus3.o_k_address, bus3.o_wdata);
    end
    rst_n = 1'b1;
    tick(2);
    n_chk++;
    if (ctl !== 7'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset ctl=%b required 0000000", ctl);
    end
  endtask

  task automatic test_write();
    bus.i_req[0] = 1'b1; bus.i_we[0] = 1'b1; bus.i_addr0 = 3'd5; bus.i_wdata0 = 8'hA5;
    tick(1);
    n_chk++;
    if (ctl !== 7'b01_00_1_0_0 || bus.o_k_address !== 3'd5 || bus.o_wdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL t1_setup ctl=%b addr=%0d wdata=%h required ctl=0100100 addr=5 wdata=a5",
               ctl, bus.o_k_address, bus.o_wdata);
    end
    bus.i_req[0] = 1'b0;
    tick(1);
    n_chk++;
    if (ctl !== 7'b00_00_1_1_0 || bus.o_k_address !== 3'd5) begin
      n_fail++;
      $display("FAIL t1_access ctl=%b addr=%0d required ctl=0000110 addr=5", ctl, bus.o_k_address);
    end
    tick(1);
    n_chk++;
    if (ctl !== 7'b00_01_0_0_0 || bus.o_k_address !== 3'd5) begin
      n_fail++;
      $display("FAIL t1_done ctl=%b addr=%0d required ctl=0001000 addr=5", ctl, bus.o_k_address);
    end
    tick(1);
    n_chk++;
    if (ctl !== 7'd0 || bus.o_k_address !== 3'd5 || bus.o_wdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL t1_idle_hold ctl=%b addr=%0d wdata=%h required ctl=0 addr=5 wdata=a5",
               ctl, bus.o_k_address, bus.o_wdata);
    end
  endtask

  task automatic test_read();
    bus.i_req[1] = 1'b1; bus.i_we[1] = 1'b0; bus.i_addr1 = 3'd5;
    tick(1);
    n_chk++;
    if (ctl !== 7'b10_00_1_0_0) begin
      n_fail++;
      $display("FAIL t2_setup ctl=%b required 1000100", ctl);
    end
    bus.i_req[1] = 1'b0;
    tick(1);
    n_chk++;
    if (ctl !== 7'b00_00_1_0_1) begin
      n_fail++;
      $display("FAIL t2_access ctl=%b required 0000101", ctl);
    end
    tick(1);
    n_chk++;
    if (ctl !== 7'b00_10_0_0_0 || bus.o_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL t2_done ctl=%b rdata=%h required ctl=0010000 rdata=a5", ctl, bus.o_rdata);
    end
    tick(3);
    n_chk++;
    if (ctl !== 7'd0 || bus.o_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL t2_rdata_hold ctl=%b rdata=%h required ctl=0 rdata=a5", ctl, bus.o_rdata);
    end
  endtask

  task automatic test_arbitration();
    int ngrant;
    int last_cyc;
    logic [1:0] exp_g;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    bus.i_req = 2'b11; bus.i_we = 2'b00; bus.i_addr0 = 3'd1; bus.i_addr1 = 3'd2;
    ngrant = 0;
    last_cyc = 0;
    for (int cyc = 1; cyc <= 40 && ngrant < 4; cyc++) begin
      tick(1);
      if (bus.o_gnt !== 2'b00) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_g = (ngrant % 2 == 0) ? 2'b01 : 2'b10;
`else
        exp_g = 2'b01;
`endif
        n_chk++;
        if (bus.o_gnt !== exp_g) begin
          n_fail++;
          $display("FAIL t3_grant%0d gnt=%b required %b", ngrant, bus.o_gnt, exp_g);
        end
        if (ngrant > 0) begin
          n_chk++;
          if (cyc - last_cyc != 4) begin
            n_fail++;
            $display("FAIL t3_spacing%0d gap=%0d required 4", ngrant, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        ngrant++;
      end
    end
    n_chk++;
    if (ngrant != 4) begin
      n_fail++;
      $display("FAIL t3_grant_count got=%0d required 4 within budget", ngrant);
    end
    bus.i_req = 2'b00;
    tick(4);
    n_chk++;
    if (ctl !== 7'd0) begin
      n_fail++;
      $display("FAIL t3_drain ctl=%b required 0000000", ctl);
    end
  endtask

  task automatic test_access_cycles();
    bus3.i_req[0] = 1'b1; bus3.i_we[0] = 1'b0; bus3.i_addr0 = 3'd2;
    tick(1);
    n_chk++;
    if (ctl3 !== 7'b01_00_1_0_0 || bus3.o_k_address !== 3'd2) begin
      n_fail++;
      $display("FAIL t4_setup ctl=%b addr=%0d required ctl=0100100 addr=2", ctl3, bus3.o_k_address);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_chk++;
      if (ctl3 !== 7'b00_00_1_0_1) begin
        n_fail++;
        $display("FAIL t4_access%0d ctl=%b required 0000101", i, ctl3);
      end
    end
    tick(1);
    n_chk++;
    if (ctl3 !== 7'b00_01_0_0_0 || bus3.o_rdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL t4_done ctl=%b rdata=%h required ctl=0001000 rdata=3c", ctl3, bus3.o_rdata);
    end
    tick(1);
    n_chk++;
    if (ctl3 !== 7'd0) begin
      n_fail++;
      $display("FAIL t4_idle_gap ctl=%b required 0000000", ctl3);
    end
    tick(1);
    n_chk++;
    if (ctl3 !== 7'b01_00_1_0_0) begin
      n_fail++;
      $display("FAIL t4_next_accept ctl=%b required 0100100", ctl3);
    end
    bus3.i_req = 2'b00;
    tick(6);
    n_chk++;
    if (ctl3 !== 7'd0 || bus3.o_rdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL t4_drain ctl=%b rdata=%h required ctl=0 rdata=3c", ctl3, bus3.o_rdata);
    end
  endtask

  task automatic test_reset_mid();
    bus.i_req[0] = 1'b1; bus.i_we[0] = 1'b1; bus.i_addr0 = 3'd3; bus.i_wdata0 = 8'h77;
    tick(2);
    n_chk++;
    if (ctl !== 7'b00_00_1_1_0) begin
      n_fail++;
      $display("FAIL t5_in_access ctl=%b required 0000110", ctl);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (ctl !== 7'd0 || bus.o_k_address !== 3'd0 || bus.o_wdata !== 8'h00 || bus.o_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL t5_async_clear ctl=%b addr=%0d wdata=%h rdata=%h required all zero",
               ctl, bus.o_k_address, bus.o_wdata, bus.o_rdata);
    end
    bus.i_req = 2'b11; bus.i_we = 2'b00; bus.i_addr0 = 3'd6; bus.i_addr1 = 3'd1;
    tick(2);
    n_chk++;
    if (ctl !== 7'd0) begin
      n_fail++;
      $display("FAIL t5_held_reset ctl=%b required 0000000", ctl);
    end
    rst_n = 1'b1;
    tick(1);
    n_chk++;
    if (ctl !== 7'b01_00_1_0_0 || bus.o_k_address !== 3'd6) begin
      n_fail++;
      $display("FAIL t5_regrant ctl=%b addr=%0d required ctl=0100100 addr=6", ctl, bus.o_k_address);
    end
    bus.i_req = 2'b00;
    tick(4);
    n_chk++;
    if (ctl !== 7'd0) begin
      n_fail++;
      $display("FAIL t5_drain ctl=%b required 0000000", ctl);
    end
  endtask

  task automatic test_addr_sweep();
    logic [2:0] a;
    logic [7:0] d;
    for (int k = 0; k < 8; k++) begin
      a = 3'(k);
      d = 8'(k * 17) ^ 8'h5A;
      bus.i_req[0] = 1'b1; bus.i_we[0] = 1'b1; bus.i_addr0 = a; bus.i_wdata0 = d;
      tick(1);
      bus.i_req[0] = 1'b0; bus.i_addr0 = ~a; bus.i_wdata0 = ~d;
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (bus.o_k_address !== a || bus.o_wdata !== d) begin
          n_fail++;
          $display("FAIL t6_latch a%0d c%0d addr=%0d wdata=%h required addr=%0d wdata=%h",
                   k, i, bus.o_k_address, bus.o_wdata, a, d);
        end
        tick(1);
      end
      bus.i_req[1] = 1'b1; bus.i_we[1] = 1'b0; bus.i_addr1 = a;
      tick(1);
      bus.i_req[1] = 1'b0;
      tick(2);
      n_chk++;
      if (bus.o_done !== 2'b10 || bus.o_rdata !== d) begin
        n_fail++;
        $display("FAIL t6_readback a%0d done=%b rdata=%h required done=10 rdata=%h",
                 k, bus.o_done, bus.o_rdata, d);
      end
      tick(1);
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    tick(2);
    test_reset();
    test_write();
    test_read();
    test_arbitration();
    test_access_cycles();
    test_reset_mid();
    test_addr_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
